// File: rtl/mmio_uart_pkg.sv
// Shared constants for the MMIO/UART bridge: register map, STATUS layout and UART states.
package mmio_uart_pkg;

    // The MMIO window is the top 16 words: every address bit above this many low bits is one.
    localparam int MMIO_REG_BITS = 4;

    // Register offsets inside the MMIO window.
    localparam logic [3:0] REG_TX_DATA = 4'h0;
    localparam logic [3:0] REG_STATUS  = 4'h1;
    localparam logic [3:0] REG_CYC_LO  = 4'h2;
    localparam logic [3:0] REG_CYC_HI  = 4'h3;

    // STATUS register bit positions; the FIFO count occupies an 8-bit field starting at ST_COUNT_LSB.
    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 8;

    // UART transmitter states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_tx_fsm.sv
// 8N1 serialiser: pulls one byte from the FIFO when idle and shifts it out LSB first.
module uart_tx_fsm
    import mmio_uart_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_byte,
    input  logic       valid,
    output logic       pop,
    output logic       tx,
    output logic       busy
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(BAUD_DIV - 1);

    uart_state_t     state;
    logic [7:0]      shift;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;

    // A byte is taken only from IDLE, so a byte pushed this cycle cannot be popped before it lands.
    assign pop  = (state == S_IDLE) && valid;
    assign busy = (state != S_IDLE);

    // Frame sequencer; tx is registered so it changes exactly on bit boundaries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            shift    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (valid) begin
                        shift    <= tx_byte;
                        baud_cnt <= BAUD_LOAD;
                        tx       <= 1'b0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_LOAD;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_LOAD;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_cnt == '0) begin
                        tx    <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_bridge.sv
// CPU bus bridge: passes accesses to async SRAM, decodes the top 16 words as UART/counter registers.
module mmio_uart_bridge
    import mmio_uart_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int BAUD_DIV   = 434
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_dq,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  uart_tx,
    output logic                  tx_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                  mmio;
    logic [3:0]            reg_sel;
    logic                  rd_ok;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] mmio_rdata;

    logic [7:0]            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  fsm_busy;

    logic                  overflow;
    logic [31:0]           cyc;
    logic [15:0]           hi_shadow;

    // A simultaneous read and write request is illegal and is treated as no access at all.
    assign rd_ok   = mem_read & ~mem_write;
    assign wr_ok   = mem_write & ~mem_read;
    assign mmio    = &bus_addr[ADDR_WIDTH-1:MMIO_REG_BITS];
    assign reg_sel = bus_addr[3:0];

    assign sram_addr = bus_addr;
    assign sram_ce_n = mmio | ~(rd_ok | wr_ok);
    assign sram_oe_n = mmio | ~rd_ok;
    assign sram_we_n = mmio | ~wr_ok;
    assign sram_dq   = (!mmio && wr_ok) ? bus_data : 'z;
    assign bus_data  = rd_ok ? (mmio ? mmio_rdata : sram_dq) : 'z;

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = mmio && wr_ok && (reg_sel == REG_TX_DATA) && !fifo_full;
    assign tx_busy    = !fifo_empty || fsm_busy;

    // Register read mux; only registered state feeds it so reads never see a mid-cycle update.
    always_comb begin
        mmio_rdata = '0;
        case (reg_sel)
            REG_STATUS: begin
                mmio_rdata[ST_EMPTY]              = fifo_empty;
                mmio_rdata[ST_FULL]               = fifo_full;
                mmio_rdata[ST_BUSY]               = tx_busy;
                mmio_rdata[ST_OVERFLOW]           = overflow;
                mmio_rdata[ST_COUNT_LSB +: 8]     = 8'(count);
            end
            REG_CYC_LO: mmio_rdata = DATA_WIDTH'(cyc[15:0]);
            REG_CYC_HI: mmio_rdata = DATA_WIDTH'(hi_shadow);
            default:    mmio_rdata = '0;
        endcase
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus_data[7:0];
        end
    end

    // FIFO pointers and occupancy; a push and pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag: set by a TX_DATA write into a full FIFO, cleared by any STATUS write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (mmio && wr_ok && (reg_sel == REG_TX_DATA) && fifo_full) begin
            overflow <= 1'b1;
        end else if (mmio && wr_ok && (reg_sel == REG_STATUS)) begin
            overflow <= 1'b0;
        end
    end

    // Free-running counter; reading the low half snapshots the high half so a 32-bit read is coherent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc       <= '0;
            hi_shadow <= '0;
        end else begin
            cyc <= cyc + 32'd1;
            if (mmio && rd_ok && (reg_sel == REG_CYC_LO)) begin
                hi_shadow <= cyc[31:16];
            end
        end
    end

    uart_tx_fsm #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk     (clk),
        .reset   (reset),
        .tx_byte (fifo_mem[rd_ptr]),
        .valid   (!fifo_empty),
        .pop     (pop),
        .tx      (uart_tx),
        .busy    (fsm_busy)
    );

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Directed bench for mmio_uart_bridge: bus vector table, UART waveform, FIFO, counter and reset cases.
module tb_mmio_uart_bridge;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int BD = 4;

    logic          clk;
    logic          reset;
    logic [AW-1:0] bus_addr;
    logic          mem_read;
    logic          mem_write;
    logic          tb_drv;
    logic [DW-1:0] tb_wdata;
    wire  [DW-1:0] bus_data;
    wire  [DW-1:0] sram_dq;
    logic [AW-1:0] sram_addr;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic          uart_tx;
    logic          tx_busy;

    int            n_cmp;
    int            n_fail;

    logic [DW-1:0] sram_mem [256];
    logic [7:0]    rx_q [$];
    int            rx_frame_err;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          chk_bus;
        logic [DW-1:0] exp_bus;
        logic [2:0]    exp_strobe;
    } vec_t;

    vec_t vecs [15];

    mmio_uart_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (8),
        .BAUD_DIV   (BD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .sram_addr (sram_addr),
        .sram_dq   (sram_dq),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .uart_tx   (uart_tx),
        .tx_busy   (tx_busy)
    );

    assign bus_data = tb_drv ? tb_wdata : 'z;
    assign sram_dq  = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[7:0]] : 'z;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Simple SRAM model: captures data on the clock edge while the write strobe is low.
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            sram_mem[sram_addr[7:0]] <= sram_dq;
        end
    end

    // Serial receiver: samples each bit mid-way and drops any frame interrupted by reset.
    initial begin
        logic [7:0] rx_byte;
        bit         rx_abort;
        rx_frame_err = 0;
        forever begin
            @(negedge clk);
            if (reset && uart_tx == 1'b0) begin
                rx_byte  = '0;
                rx_abort = 1'b0;
                for (int k = 1; k <= 38; k++) begin
                    @(negedge clk);
                    if (!reset) rx_abort = 1'b1;
                    if (k >= 6 && k <= 34 && ((k - 6) % 4) == 0) rx_byte[(k - 6) / 4] = uart_tx;
                    if (k == 38 && !rx_abort && uart_tx != 1'b1) rx_frame_err++;
                end
                if (!rx_abort) rx_q.push_back(rx_byte);
            end
        end
    end

    // Watchdog so a stuck design still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic rd, input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata);
        mem_read  = rd;
        mem_write = wr;
        bus_addr  = addr;
        tb_wdata  = wdata;
        tb_drv    = wr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic waitIdle(input int max_cycles);
        int n;
        n = 0;
        while (tx_busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_idle", {31'd0, tx_busy}, 32'd0);
    endtask

    // Main sequence.
    initial begin
        logic [39:0] cap;
        logic [39:0] exp_bits;
        logic [7:0]  exp_byte;
        logic [7:0]  exp_rx [12];
        bit          stayed_high;
        int          rx_before;

        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0);

        // Bus vector table: {rd, wr, addr, wdata, chk_bus, exp_bus, {ce_n, oe_n, we_n}}.
        vecs[0]  = '{1'b0, 1'b0, 20'h00123, 16'h0000, 1'b0, 16'h0000, 3'b111};
        vecs[1]  = '{1'b0, 1'b1, 20'h00123, 16'hBEEF, 1'b0, 16'h0000, 3'b010};
        vecs[2]  = '{1'b1, 1'b0, 20'h00123, 16'h0000, 1'b1, 16'hBEEF, 3'b001};
        vecs[3]  = '{1'b1, 1'b1, 20'h00123, 16'h1234, 1'b0, 16'h0000, 3'b111};
        vecs[4]  = '{1'b1, 1'b0, 20'h00123, 16'h0000, 1'b1, 16'hBEEF, 3'b001};
        vecs[5]  = '{1'b0, 1'b1, 20'hFFFEF, 16'h1357, 1'b0, 16'h0000, 3'b010};
        vecs[6]  = '{1'b1, 1'b0, 20'hFFFEF, 16'h0000, 1'b1, 16'h1357, 3'b001};
        vecs[7]  = '{1'b1, 1'b0, 20'hFFFF1, 16'h0000, 1'b1, 16'h0001, 3'b111};
        vecs[8]  = '{1'b1, 1'b0, 20'hFFFF0, 16'h0000, 1'b1, 16'h0000, 3'b111};
        vecs[9]  = '{1'b1, 1'b0, 20'hFFFF7, 16'h0000, 1'b1, 16'h0000, 3'b111};
        vecs[10] = '{1'b0, 1'b1, 20'hFFFF5, 16'h00FF, 1'b0, 16'h0000, 3'b111};
        vecs[11] = '{1'b1, 1'b1, 20'hFFFF0, 16'h0055, 1'b0, 16'h0000, 3'b111};
        vecs[12] = '{1'b1, 1'b0, 20'hFFFF1, 16'h0000, 1'b1, 16'h0001, 3'b111};
        vecs[13] = '{1'b1, 1'b0, 20'hFFFF3, 16'h0000, 1'b1, 16'h0000, 3'b111};
        vecs[14] = '{1'b0, 1'b0, 20'hFFFF0, 16'h0000, 1'b0, 16'h0000, 3'b111};

        exp_rx = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h3C, 8'hC3};

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
        checkOutput("reset_tx_busy", {31'd0, tx_busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Table-driven bus checks.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            #1;
            checkOutput($sformatf("vec%0d_strobe", i), {29'd0, sram_ce_n, sram_oe_n, sram_we_n},
                        {29'd0, vecs[i].exp_strobe});
            if (!vecs[i].exp_strobe[2]) begin
                checkOutput($sformatf("vec%0d_sram_addr", i), {12'd0, sram_addr}, {12'd0, vecs[i].addr});
            end
            if (vecs[i].chk_bus) begin
                checkOutput($sformatf("vec%0d_bus", i), {16'd0, bus_data}, {16'd0, vecs[i].exp_bus});
            end
        end

        // Single byte 0xA5: check the full 40-cycle frame bit pattern.
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 20'hFFFF0, 16'h00A5);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 20'h00000, 16'h0000);
        #1;
        checkOutput("byte_busy_after_push", {31'd0, tx_busy}, 32'd1);
        exp_byte = 8'hA5;
        for (int j = 0; j < 40; j++) begin
            if (j < 4)       exp_bits[j] = 1'b0;
            else if (j < 36) exp_bits[j] = exp_byte[(j - 4) / 4];
            else             exp_bits[j] = 1'b1;
        end
        for (int k = 2; k <= 41; k++) begin
            @(negedge clk);
            cap[k - 2] = uart_tx;
        end
        checkOutput("byte_waveform_lo", cap[31:0], exp_bits[31:0]);
        checkOutput("byte_waveform_hi", {24'd0, cap[39:32]}, {24'd0, exp_bits[39:32]});
        checkOutput("byte_busy_in_stop", {31'd0, tx_busy}, 32'd1);
        @(negedge clk);
        checkOutput("byte_busy_done", {31'd0, tx_busy}, 32'd0);

        // FIFO fill: nine back-to-back pushes, the first is popped one cycle later.
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b1, 20'hFFFF0, 16'(i));
        end
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 20'hFFFF1, 16'h0000);
        #1;
        checkOutput("fifo_full_no_drop", {16'd0, bus_data}, 32'h0806);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 20'hFFFF0, 16'h000A);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 20'hFFFF0, 16'h000B);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 20'hFFFF1, 16'h0000);
        #1;
        checkOutput("fifo_overflow", {16'd0, bus_data}, 32'h080E);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 20'hFFFF1, 16'h0000);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 20'hFFFF1, 16'h0000);
        #1;
        checkOutput("fifo_overflow_clear", {16'd0, bus_data}, 32'h0806);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 20'h00000, 16'h0000);
        waitIdle(600);

        // Simultaneous push and pop while the FSM leaves IDLE.
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 20'hFFFF0, 16'h003C);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 20'hFFFF0, 16'h00C3);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 20'hFFFF1, 16'h0000);
        #1;
        checkOutput("pushpop_count", {16'd0, bus_data}, 32'h0104);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 20'h00000, 16'h0000);
        waitIdle(200);

        // Cycle counter snapshot across a low-half carry.
        @(negedge clk);
        force dut.cyc = 32'h0001FFFF;
        #1;
        release dut.cyc;
        applyStimulus(1'b1, 1'b0, 20'hFFFF2, 16'h0000);
        #1;
        checkOutput("cyc_lo_snap", {16'd0, bus_data}, 32'h0000FFFF);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 20'hFFFF3, 16'h0000);
        #1;
        checkOutput("cyc_hi_snap", {16'd0, bus_data}, 32'h00000001);

        // Cycle counter wrap from all ones to zero.
        @(negedge clk);
        force dut.cyc = 32'hFFFFFFFF;
        #1;
        release dut.cyc;
        applyStimulus(1'b1, 1'b0, 20'hFFFF2, 16'h0000);
        #1;
        checkOutput("cyc_wrap_lo_before", {16'd0, bus_data}, 32'h0000FFFF);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 20'hFFFF3, 16'h0000);
        #1;
        checkOutput("cyc_wrap_hi_before", {16'd0, bus_data}, 32'h0000FFFF);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 20'hFFFF2, 16'h0000);
        #1;
        checkOutput("cyc_wrap_lo_after", {16'd0, bus_data}, 32'h00000001);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 20'hFFFF3, 16'h0000);
        #1;
        checkOutput("cyc_wrap_hi_after", {16'd0, bus_data}, 32'h00000000);

        // Reset asserted in the middle of a frame's data bits.
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 20'hFFFF0, 16'h005A);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 20'h00000, 16'h0000);
        repeat (12) @(negedge clk);
        rx_before = rx_q.size();
        reset = 1'b0;
        #1;
        checkOutput("midreset_uart_tx", {31'd0, uart_tx}, 32'd1);
        checkOutput("midreset_tx_busy", {31'd0, tx_busy}, 32'd0);
        applyStimulus(1'b1, 1'b0, 20'hFFFF2, 16'h0000);
        #1;
        checkOutput("midreset_cyc_lo", {16'd0, bus_data}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 20'hFFFF1, 16'h0000);
        #1;
        checkOutput("postreset_status", {16'd0, bus_data}, 32'h0001);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 20'h00000, 16'h0000);
        stayed_high = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) stayed_high = 1'b0;
        end
        checkOutput("postreset_line_quiet", {31'd0, stayed_high}, 32'd1);
        checkOutput("postreset_no_rx", rx_q.size(), rx_before);

        // Everything transmitted arrives complete and in order.
        checkOutput("rx_frame_errors", rx_frame_err, 32'd0);
        checkOutput("rx_count", rx_q.size(), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < rx_q.size()) begin
                checkOutput($sformatf("rx_byte%0d", i), {24'd0, rx_q[i]}, {24'd0, exp_rx[i]});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
